// File: rtl/fir_tx_pkg.sv
// Shared constants, coefficients and FSM encoding for the 2x polyphase FIR interpolator.
package fir_tx_pkg;

  localparam int unsigned NB_COEF  = 16;
  localparam int unsigned NBF_COEF = 15;
  localparam int unsigned NBF_DATA = 15;
  localparam int unsigned NB_PROD  = 32;
  localparam int unsigned NB_TRUNC = 17;

  // h = [C0, C1, C1, C0], S(16,15)
  localparam logic signed [NB_COEF-1:0] C0 = 16'sh04F0;
  localparam logic signed [NB_COEF-1:0] C1 = 16'sh3B0F;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPh0  = 2'd1,
    StPh1  = 2'd2
  } fir_state_e;

endpackage

// File: rtl/SatTruncFP.sv
// Fixed-point floor truncation of fractional bits with saturation of the integer part.
module SatTruncFP #(
  parameter int unsigned NB_XI  = 32,
  parameter int unsigned NBF_XI = 30,
  parameter int unsigned NB_XO  = 17,
  parameter int unsigned NBF_XO = 15
) (
  input  logic signed [NB_XI-1:0] i_data,
  output logic signed [NB_XO-1:0] o_data
);

  localparam int unsigned DROP = NBF_XI - NBF_XO;

  logic signed [NB_XI-1:0]       shifted;
  logic        [NB_XI-NB_XO:0]   upper;

  // Arithmetic shift gives floor rounding for negative values.
  assign shifted = i_data >>> DROP;
  assign upper   = shifted[NB_XI-1:NB_XO-1];

  always_comb begin
    o_data = shifted[NB_XO-1:0];
    if (!((&upper) || (~|upper))) begin
      o_data = shifted[NB_XI-1] ? {1'b1, {(NB_XO-1){1'b0}}} : {1'b0, {(NB_XO-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_interp2_polyphase.sv
// 4-tap symmetric FIR interpolator by 2: one input sample in, even then odd phase out.
module fir_interp2_polyphase
  import fir_tx_pkg::*;
#(
  parameter int unsigned NB_INPUT  = 16,
  parameter int unsigned NB_OUTPUT = 18
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [NB_INPUT-1:0]  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic signed [NB_OUTPUT-1:0] o_data,
  output logic                        o_valid,
  input  logic                        i_ready
);

  fir_state_e state_q, state_d;

  logic signed [NB_INPUT-1:0]  x1_q, x1_d, x2_q, x2_d;
  logic signed [NB_OUTPUT-1:0] data_q, data_d;
  logic                        valid_q, valid_d;
  logic                        accept;

  logic signed [NB_PROD-1:0]   prod_e0, prod_e1, prod_o0, prod_o1;
  logic signed [NB_TRUNC-1:0]  trunc_e0, trunc_e1, trunc_o0, trunc_o1;
  logic signed [NB_OUTPUT-1:0] y_even, y_odd;

  // Even phase uses the post-shift delay line: x1 = i_data, x2 = current x1.
  assign prod_e0 = NB_PROD'(C0) * NB_PROD'(i_data);
  assign prod_e1 = NB_PROD'(C1) * NB_PROD'(x1_q);
  // Odd phase is produced one cycle after the accept, from the registered line.
  assign prod_o0 = NB_PROD'(C1) * NB_PROD'(x1_q);
  assign prod_o1 = NB_PROD'(C0) * NB_PROD'(x2_q);

  SatTruncFP #(
    .NB_XI (NB_PROD),
    .NBF_XI(NBF_COEF + NBF_DATA),
    .NB_XO (NB_TRUNC),
    .NBF_XO(NBF_DATA)
  ) u_trunc_e0 (
    .i_data(prod_e0),
    .o_data(trunc_e0)
  );

  SatTruncFP #(
    .NB_XI (NB_PROD),
    .NBF_XI(NBF_COEF + NBF_DATA),
    .NB_XO (NB_TRUNC),
    .NBF_XO(NBF_DATA)
  ) u_trunc_e1 (
    .i_data(prod_e1),
    .o_data(trunc_e1)
  );

  SatTruncFP #(
    .NB_XI (NB_PROD),
    .NBF_XI(NBF_COEF + NBF_DATA),
    .NB_XO (NB_TRUNC),
    .NBF_XO(NBF_DATA)
  ) u_trunc_o0 (
    .i_data(prod_o0),
    .o_data(trunc_o0)
  );

  SatTruncFP #(
    .NB_XI (NB_PROD),
    .NBF_XI(NBF_COEF + NBF_DATA),
    .NB_XO (NB_TRUNC),
    .NBF_XO(NBF_DATA)
  ) u_trunc_o1 (
    .i_data(prod_o1),
    .o_data(trunc_o1)
  );

  assign y_even = NB_OUTPUT'(trunc_e0) + NB_OUTPUT'(trunc_e1);
  assign y_odd  = NB_OUTPUT'(trunc_o0) + NB_OUTPUT'(trunc_o1);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    o_ready = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        o_ready = 1'b1;
        if (i_valid) begin
          accept  = 1'b1;
          data_d  = y_even;
          valid_d = 1'b1;
          state_d = StPh0;
        end
      end
      StPh0: begin
        if (i_ready) begin
          data_d  = y_odd;
          state_d = StPh1;
        end
      end
      StPh1: begin
        o_ready = i_ready;
        if (i_ready) begin
          if (i_valid) begin
            accept  = 1'b1;
            data_d  = y_even;
            state_d = StPh0;
          end else begin
            valid_d = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  assign x1_d = accept ? i_data : x1_q;
  assign x2_d = accept ? x1_q : x2_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      x1_q    <= '0;
      x2_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_fir_interp2_polyphase.sv
// Self-checking bench: vector table plus hand sequences, outputs checked through a scoreboard.
module tb_fir_interp2_polyphase;

  logic               clk;
  logic               rst;
  logic signed [15:0] din;
  logic               din_valid;
  logic               din_ready;
  logic signed [17:0] dout;
  logic               dout_valid;
  logic               dout_ready;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [17:0] exp_q[$];

  typedef struct {
    logic               rst;
    logic signed [15:0] din;
    logic signed [17:0] ev;
    logic signed [17:0] od;
  } vec_t;

  vec_t vecs[6];

  fir_interp2_polyphase #(
    .NB_INPUT (16),
    .NB_OUTPUT(18)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_data (din),
    .i_valid(din_valid),
    .o_ready(din_ready),
    .o_data (dout),
    .o_valid(dout_valid),
    .i_ready(dout_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string name, input logic signed [17:0] act,
                           input logic signed [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Scoreboard: every output beat taken by the sink is popped and compared.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %0d expected none", dout);
      end else begin
        check_val("scoreboard", dout, exp_q.pop_front());
      end
    end
  end

  task automatic drain();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    drain();
    rst       = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_bit("rst_o_valid", dout_valid, 1'b0);
    check_val("rst_o_data", dout, 18'sd0);
    check_bit("rst_o_ready", din_ready, 1'b1);
  endtask

  task automatic send(input logic signed [15:0] d, input logic signed [17:0] ev,
                      input logic signed [17:0] od);
    bit acc;
    acc       = 1'b0;
    din       = d;
    din_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (din_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(ev);
      exp_q.push_back(od);
    end else begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: got o_ready=0 expected 1");
    end
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;

    vecs[0] = '{1'b1, 16'sh4000, 18'sd632,    18'sd7559};
    vecs[1] = '{1'b0, 16'sh0000, 18'sd7559,   18'sd632};
    vecs[2] = '{1'b1, 16'sh8000, -18'sd1264,  -18'sd15119};
    vecs[3] = '{1'b0, 16'sh8000, -18'sd16383, -18'sd16383};
    vecs[4] = '{1'b1, 16'shFFFF, -18'sd1,     -18'sd1};
    vecs[5] = '{1'b0, 16'sh0000, -18'sd1,     -18'sd1};

    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst) reset_dut();
      send(vecs[i].din, vecs[i].ev, vecs[i].od);
    end
    drain();

    // Backpressure in PH0: output must hold for three stalled cycles.
    reset_dut();
    send(16'sh4000, 18'sd632, 18'sd7559);
    dout_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("bp_hold_data", dout, 18'sd632);
      check_bit("bp_hold_valid", dout_valid, 1'b1);
      check_bit("bp_hold_ready", din_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val("bp_release_data", dout, 18'sd7559);
    drain();

    // Back-to-back: i_valid held high, second sample taken in PH1.
    reset_dut();
    din       = 16'sh4000;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(18'sd632);
    exp_q.push_back(18'sd7559);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_bit("b2b_valid", dout_valid, 1'b1);
      check_bit("b2b_ready", din_ready, (k % 2) == 1);
      if (k == 1) begin
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        exp_q.push_back(18'sd8191);
        exp_q.push_back(18'sd8191);
      end
    end
    drain();

    // Reset while in PH0 drops the pending outputs and clears the delay line.
    reset_dut();
    dout_ready = 1'b0;
    send(16'sh4000, 18'sd632, 18'sd7559);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_bit("midrst_o_valid", dout_valid, 1'b0);
    check_val("midrst_o_data", dout, 18'sd0);
    check_bit("midrst_o_ready", din_ready, 1'b1);
    dout_ready = 1'b1;
    send(16'sh4000, 18'sd632, 18'sd7559);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
